// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in by reusing a single
//   4-bit carry-lookahead slice, one nibble per clock, least-significant first.
//   A valid/ready request is accepted in IDLE. The block spends NIBBLES cycles
//   in RUN, then presents the result in DONE until the consumer takes it.
//
// Parameters
//   NIBBLES   number of 4-bit slices per operand (2..16)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  requester presents a, b, c_in
//   req_ready  block can accept an operand set (0 while in reset)
//   a, b       W-bit operands, sampled on accept
//   c_in       carry into nibble 0, sampled on accept
//   rsp_valid  result available
//   rsp_ready  consumer takes the result
//   s          W-bit sum, holds the last completed result
//   c_out      carry out of the most-significant nibble
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead slice: all four carries come from generate/propagate
// terms directly, with no ripple between the bit positions.
module CarryLookAheadAdder4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] s,
  output logic                 c_out
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     s_q;
  logic             c_out_q;
  // Goes high on the first clock edge after reset release; keeps req_ready
  // low for the whole reset interval even though state already reads IDLE.
  logic             out_of_reset;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_c;

  // The single shared slice always looks at the nibble selected by idx; its
  // result only matters in RUN.
  assign slice_a = a_q[4*idx +: 4];
  assign slice_b = b_q[4*idx +: 4];

  CarryLookAheadAdder4Bit u_cla (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make result order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      carry        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      c_out_q      <= 1'b0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid && out_of_reset) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_q[4*idx +: 4] <= slice_s;
          carry           <= slice_c;
          if (idx == LAST_IDX) begin
            // idx parks on the last nibble; it is cleared again on accept.
            c_out_q <= slice_c;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: outputs are pure continuous decodes of registered state, so there
  // is no incompletely-assigned combinational path that could become a latch.
  assign req_ready = out_of_reset && (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed and randomized checks of nibble_serial_adder. A NIBBLES=4 instance
//   covers reset, latency, stalls, ignored inputs, reset abort and random
//   back-to-back traffic. A bank of NIBBLES=2 instances splits the full
//   a x b x c_in space between them. Expected sums come from plain W+1-bit
//   integer addition.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nibble_serial_adder;

  localparam int LANES     = 64;
  localparam int PER_LANE  = 131072 / LANES;
  localparam int MAX_FAILS = 20;

  int compared   = 0;
  int mismatched = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        req_valid;
  logic        req_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] s;
  logic        c_out;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .s         (s),
    .c_out     (c_out)
  );

  // NIBBLES=2 lanes
  logic [LANES-1:0]      l_req_valid;
  logic [LANES-1:0]      l_req_ready;
  logic [LANES-1:0][7:0] l_a;
  logic [LANES-1:0][7:0] l_b;
  logic [LANES-1:0]      l_c_in;
  logic [LANES-1:0]      l_rsp_valid;
  logic [LANES-1:0]      l_rsp_ready;
  logic [LANES-1:0][7:0] l_s;
  logic [LANES-1:0]      l_c_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    nibble_serial_adder #(.NIBBLES(2)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (l_req_valid[k]),
      .req_ready (l_req_ready[k]),
      .a         (l_a[k]),
      .b         (l_b[k]),
      .c_in      (l_c_in[k]),
      .rsp_valid (l_rsp_valid[k]),
      .rsp_ready (l_rsp_ready[k]),
      .s         (l_s[k]),
      .c_out     (l_c_out[k])
    );
  end

  function automatic logic [16:0] model_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
    return 17'(x) + 17'(y) + 17'(ci);
  endfunction

  // Present an operand set at a negedge while IDLE; returns at the first
  // negedge after the accepting edge.
  task automatic accept(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    a         = va;
    b         = vb;
    c_in      = vc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at negedge 1 after accept; lat is the negedge index when rsp_valid
  // is first seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      compared++;
      mismatched++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    compared++;
    if ({req_ready, rsp_valid, s, c_out} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%b valid=%b s=%h c=%b required all 0",
               req_ready, rsp_valid, s, c_out);
    end
    compared++;
    if (l_req_ready !== '0 || l_rsp_valid !== '0) begin
      mismatched++;
      $display("FAIL reset_lanes: ready=%h valid=%h required 0", l_req_ready, l_rsp_valid);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_before_edge: req_ready=%b required 0", req_ready);
    end
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_after_edge: req_ready=%b rsp_valid=%b required 1/0",
               req_ready, rsp_valid);
    end
    compared++;
    if (l_req_ready !== '1) begin
      mismatched++;
      $display("FAIL lane_ready_after_edge: %h required all ones", l_req_ready);
    end
  endtask

  task automatic test_carry_wrap;
    int lat;
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_rsp(lat);
    compared++;
    if (lat != 5) begin
      mismatched++;
      $display("FAIL wrap_latency: got %0d cycles required 5", lat);
    end
    compared++;
    if ({c_out, s} !== 17'h1_0000) begin
      mismatched++;
      $display("FAIL wrap_result: got c=%b s=%h required c=1 s=0000", c_out, s);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || {c_out, s} !== 17'h1_0000) begin
      mismatched++;
      $display("FAIL wrap_idle_hold: valid=%b ready=%b c=%b s=%h required 0/1/1/0000",
               rsp_valid, req_ready, c_out, s);
    end
  endtask

  task automatic test_stall;
    int lat;
    bit bad;
    accept(16'h1234, 16'h4321, 1'b1);
    wait_rsp(lat);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || s !== 16'h5556 || c_out !== 1'b0 || req_ready !== 1'b0)
        bad = 1'b1;
      @(negedge clk);
    end
    compared++;
    if (bad || rsp_valid !== 1'b1 || s !== 16'h5556 || c_out !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_hold: valid=%b s=%h c=%b required 1/5556/0 for 10 cycles",
               rsp_valid, s, c_out);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_ignore_inputs;
    int n;
    bit ready_seen;
    accept(16'h00FF, 16'h0001, 1'b0);
    ready_seen = 1'b0;
    n          = 1;
    rsp_ready  = 1'b1;
    while (!rsp_valid && n < 20) begin
      req_valid = 1'b1;
      a         = 16'($urandom);
      b         = 16'($urandom);
      c_in      = 1'($urandom);
      if (req_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    compared++;
    if (ready_seen || n != 5) begin
      mismatched++;
      $display("FAIL ignore_busy: ready_seen=%b latency=%0d required 0/5", ready_seen, n);
    end
    compared++;
    if ({c_out, s} !== 17'h0_0100) begin
      mismatched++;
      $display("FAIL ignore_result: got c=%b s=%h required c=0 s=0100", c_out, s);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || s !== 16'h0100) begin
      mismatched++;
      $display("FAIL ignore_idle: valid=%b ready=%b s=%h required 0/1/0100",
               rsp_valid, req_ready, s);
    end
  endtask

  task automatic test_reset_abort;
    bit saw_valid;
    accept(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({req_ready, rsp_valid, s, c_out} !== 19'd0) begin
      mismatched++;
      $display("FAIL abort_async: ready=%b valid=%b s=%h c=%b required all 0",
               req_ready, rsp_valid, s, c_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_ready: req_ready=%b required 1", req_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) saw_valid = 1'b1;
      @(negedge clk);
    end
    compared++;
    if (saw_valid || s !== 16'h0000 || c_out !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_rsp: saw_valid=%b s=%h c=%b required 0/0000/0",
               saw_valid, s, c_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va, vb;
    logic        vc;
    logic [16:0] exp_sum;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      va      = 16'($urandom);
      vb      = 16'($urandom);
      vc      = 1'($urandom);
      exp_sum = model_sum(va, vb, vc);
      accept(va, vb, vc);
      wait_rsp(lat);
      compared++;
      if (lat != 5 || {c_out, s} !== exp_sum) begin
        mismatched++;
        $display("FAIL rand_op%0d: %h+%h+%b got lat=%0d sum=%h required lat=5 sum=%h",
                 i, va, vb, vc, lat, {c_out, s}, exp_sum);
      end
      repeat ($urandom_range(2)) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_exhaustive_n2;
    int          next_case [LANES];
    logic [8:0]  exp_sum   [LANES];
    bit          pending   [LANES];
    int          done_cnt;
    int          cycles;
    int          printed;
    logic [16:0] g;
    for (int k = 0; k < LANES; k++) begin
      next_case[k] = 0;
      pending[k]   = 1'b0;
    end
    done_cnt = 0;
    cycles   = 0;
    printed  = 0;
    while (done_cnt < 131072 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      for (int k = 0; k < LANES; k++) begin
        if (l_rsp_valid[k] && pending[k]) begin
          compared++;
          if ({l_c_out[k], l_s[k]} !== exp_sum[k]) begin
            mismatched++;
            if (printed < MAX_FAILS) begin
              printed++;
              $display("FAIL n2_lane%0d: got %h required %h", k, {l_c_out[k], l_s[k]},
                       exp_sum[k]);
            end
          end
          pending[k] = 1'b0;
          done_cnt++;
        end
        l_rsp_ready[k] = ($urandom_range(3) != 0);
        if (l_req_ready[k] && !pending[k] && next_case[k] < PER_LANE) begin
          g              = 17'(k * PER_LANE + next_case[k]);
          l_a[k]         = g[15:8];
          l_b[k]         = g[7:0];
          l_c_in[k]      = g[16];
          exp_sum[k]     = 9'(g[15:8]) + 9'(g[7:0]) + 9'(g[16]);
          pending[k]     = 1'b1;
          next_case[k]++;
          l_req_valid[k] = 1'b1;
        end else begin
          l_req_valid[k] = 1'b0;
        end
      end
    end
    l_req_valid = '0;
    compared++;
    if (done_cnt != 131072) begin
      mismatched++;
      $display("FAIL n2_coverage: completed %0d of 131072 within %0d cycles",
               done_cnt, cycles);
    end
  endtask

  initial begin
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    a           = '0;
    b           = '0;
    c_in        = 1'b0;
    l_req_valid = '0;
    l_rsp_ready = '0;
    l_a         = '0;
    l_b         = '0;
    l_c_in      = '0;

    test_reset();
    test_carry_wrap();
    test_stall();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    test_exhaustive_n2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; legal range 2..16.
REQ-002 SHALL define operand width W = 4*NIBBLES; every W-wide port below is exactly that width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  requester presents an operand set.
REQ-006 SHALL have port req_ready  output  1  block can accept an operand set.
REQ-007 SHALL have port a  input  W  first operand, sampled on accept.
REQ-008 SHALL have port b  input  W  second operand, sampled on accept.
REQ-009 SHALL have port c_in  input  1  carry into the least-significant nibble, sampled on accept.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-012 SHALL have port s  output  W  sum.
REQ-013 SHALL have port c_out  output  1  carry out of the most-significant nibble.

Function
REQ-014 SHALL instantiate exactly one CarryLookAheadAdder4Bit slice and compute the W-bit sum by time-multiplexing it, one nibble per clock, least-significant nibble first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: req_ready=1, rsp_valid=0; on req_valid=1, capture a, b, c_in into internal registers, clear the nibble index to 0, load the carry register with c_in, and go to RUN.
REQ-017 IDLE with req_valid=0 SHALL hold state and all registers.
REQ-018 RUN: req_ready=0, rsp_valid=0; each cycle, drive the slice with nibble[idx] of captured a and b plus the carry register, write the slice sum into s[4*idx+3:4*idx], load the slice carry-out into the carry register, and increment idx.
REQ-019 RUN SHALL transition to DONE on the cycle that processes idx = NIBBLES-1; idx SHALL NOT wrap past NIBBLES-1.
REQ-020 DONE: rsp_valid=1, s and c_out stable; c_out equals the final carry register; stay in DONE while rsp_ready=0.
REQ-021 DONE with rsp_ready=1 SHALL return to IDLE on that edge; req_ready rises the following cycle (no same-cycle accept).
REQ-022 Latency: with accept at edge T, rsp_valid SHALL be first high in the cycle after edge T+NIBBLES; throughput is one operation per NIBBLES+2 cycles at best.
REQ-023 req_valid and a/b/c_in changes outside IDLE SHALL be ignored; captured operands SHALL NOT change until the next accept.
REQ-024 rsp_ready outside DONE SHALL be ignored.
REQ-025 {c_out, s} SHALL equal a + b + c_in computed at W+1 bits for every operand combination.
REQ-026 s and c_out SHALL hold the last completed result in IDLE; while in RUN they are undefined to the consumer (rsp_valid=0).

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, idx=0, carry register=0, s=0, c_out=0, rsp_valid=0, and all captured-operand registers to 0.
REQ-028 While rst_n=0, req_ready SHALL be 0; req_ready SHALL be 1 from the first rising clk edge after rst_n deasserts.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation and discard the result; no rsp_valid pulse follows.

Verification
REQ-030 NIBBLES=4: accept a=0xFFFF, b=0x0001, c_in=0 -> in the 5th cycle after accept, rsp_valid=1, s=0x0000, c_out=1.
REQ-031 NIBBLES=4: a=0x1234, b=0x4321, c_in=1, rsp_ready held 0 for 10 cycles -> rsp_valid stays 1, s=0x5556, c_out=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-032 NIBBLES=4: accept a=0x00FF, b=0x0001, then change a/b and pulse req_valid during RUN -> result s=0x0100, c_out=0; extra request not accepted (req_ready=0).
REQ-033 NIBBLES=4: rst_n pulsed low in 2nd RUN cycle of 0x8000+0x8000 -> outputs zero asynchronously, no rsp_valid, req_ready=1 after first post-reset edge.
REQ-034 NIBBLES=2: exhaustive sweep a, b in 0..255, c_in in {0,1} with random rsp_ready stalls -> {c_out,s} == a+b+c_in for all 131072 cases, zero mismatches reported.
